// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage
// One pipeline stage between fetch and execute. It takes instruction words
// over a valid/ready handshake and decodes the 5-bit opcode into a one-hot
// ALU select and a flag-write enable. LDM/LDD/STD are followed by an
// immediate word; the stage joins the two words into a single registered
// bundle. A synchronous flush discards both held and pending work.

module alu_ctrl_stage #(
   parameter int INST_W      = 16,
   parameter bit TWO_WORD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [6:0]        out_alu_sel,
   output logic              out_flag_we,
   output logic [4:0]        out_opcode,
   output logic [INST_W-1:0] out_inst,
   output logic [INST_W-1:0] out_imm,
   output logic              out_imm_valid
);

   // Opcodes that need special handling
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SETC = 5'b00001;
   localparam logic [4:0] OP_INC  = 5'b00010;
   localparam logic [4:0] OP_CLRC = 5'b00011;
   localparam logic [4:0] OP_LDM  = 5'b00111;
   localparam logic [4:0] OP_STD  = 5'b01110;
   localparam logic [4:0] OP_LDD  = 5'b01111;
   localparam logic [4:0] OP_DEC  = 5'b10000;
   localparam logic [4:0] OP_SUB  = 5'b10001;
   localparam logic [4:0] OP_OR   = 5'b10010;
   localparam logic [4:0] OP_AND  = 5'b10011;
   localparam logic [4:0] OP_SHL  = 5'b10100;
   localparam logic [4:0] OP_SHR  = 5'b10101;
   localparam logic [4:0] OP_NOT  = 5'b10110;
   localparam logic [4:0] OP_NOP  = 5'b11111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,   // next word is an instruction
      ST_IMM  = 1'b1    // first word held, next word is its immediate
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [INST_W-1:0]   r_first;
   logic                r_out_valid;
   logic [6:0]          r_alu_sel;
   logic                r_flag_we;
   logic [4:0]          r_opcode;
   logic [INST_W-1:0]   r_inst;
   logic [INST_W-1:0]   r_imm;
   logic                r_imm_valid;

   logic                w_in_ready;
   logic                w_accept;
   logic [4:0]          w_in_opcode;
   logic                w_two_word;
   logic                w_latch_first;
   logic                w_load;
   logic [INST_W-1:0]   w_load_inst;
   logic [INST_W-1:0]   w_load_imm;
   logic                w_load_imm_valid;
   logic [4:0]          w_load_opcode;
   logic [6:0]          w_dec_sel;
   logic                w_dec_flag_we;

   // A word can only be taken when the output slot is free or being drained
   // this cycle; this also applies to the immediate, since it completes a bundle.
   assign w_in_ready  = !flush && (!r_out_valid || out_ready);
   assign w_accept    = in_valid && w_in_ready;
   assign w_in_opcode = in_inst[INST_W-1 -: 5];
   assign w_two_word  = TWO_WORD_EN &&
                        ((w_in_opcode == OP_LDM) ||
                         (w_in_opcode == OP_STD) ||
                         (w_in_opcode == OP_LDD));

   // Next-state and load control; flush forces IDLE and blocks acceptance
   always_comb begin
      w_state_next     = r_state;
      w_latch_first    = 1'b0;
      w_load           = 1'b0;
      w_load_inst      = in_inst;
      w_load_imm       = '0;
      w_load_imm_valid = 1'b0;
      if (flush) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_two_word) begin
                     w_latch_first = 1'b1;
                     w_state_next  = ST_IMM;
                  end else begin
                     w_load = 1'b1;
                  end
               end
            end
            ST_IMM: begin
               // The word accepted here is data only and is never decoded
               if (w_accept) begin
                  w_load           = 1'b1;
                  w_load_inst      = r_first;
                  w_load_imm       = in_inst;
                  w_load_imm_valid = 1'b1;
                  w_state_next     = ST_IDLE;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign w_load_opcode = w_load_inst[INST_W-1 -: 5];

   // Opcode to one-hot ALU select; everything not listed falls back to ADD
   always_comb begin
      w_dec_sel = 7'b0000001;
      case (w_load_opcode)
         OP_NOP:          w_dec_sel = 7'b0000000;
         OP_DEC, OP_SUB:  w_dec_sel = 7'b0000010;
         OP_AND:          w_dec_sel = 7'b0000100;
         OP_OR:           w_dec_sel = 7'b0001000;
         OP_NOT:          w_dec_sel = 7'b0010000;
         OP_SHR:          w_dec_sel = 7'b0100000;
         OP_SHL:          w_dec_sel = 7'b1000000;
         default:         w_dec_sel = 7'b0000001;
      endcase
   end

   // Opcodes whose result updates the condition code register
   always_comb begin
      w_dec_flag_we = 1'b0;
      case (w_load_opcode)
         OP_ADD, OP_SETC, OP_INC, OP_CLRC,
         OP_DEC, OP_SUB, OP_OR, OP_AND,
         OP_SHL, OP_SHR, OP_NOT:  w_dec_flag_we = 1'b1;
         default:                 w_dec_flag_we = 1'b0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Holds the first word of a two-word op while waiting for its immediate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_first <= '0;
      end else if (w_latch_first) begin
         r_first <= in_inst;
      end
   end

   // Output bundle register: load wins over consume, flush wins over both
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_alu_sel   <= '0;
         r_flag_we   <= 1'b0;
         r_opcode    <= '0;
         r_inst      <= '0;
         r_imm       <= '0;
         r_imm_valid <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_alu_sel   <= w_dec_sel;
         r_flag_we   <= w_dec_flag_we;
         r_opcode    <= w_load_opcode;
         r_inst      <= w_load_inst;
         r_imm       <= w_load_imm;
         r_imm_valid <= w_load_imm_valid;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready      = w_in_ready;
   assign out_valid     = r_out_valid;
   assign out_alu_sel   = r_alu_sel;
   assign out_flag_we   = r_flag_we;
   assign out_opcode    = r_opcode;
   assign out_inst      = r_inst;
   assign out_imm       = r_imm;
   assign out_imm_valid = r_imm_valid;

endmodule
